// File: rtl/hier_path_decoder.sv
// Receiving end of the hierarchy-path token stream: folds one switch index per
// token into a packed path, a depth and a flat mixed-radix leaf index.
module hier_path_decoder #(
    parameter int DEPTH   = 10,
    parameter int FANOUT  = 5,
    parameter int DIGIT_W = 4,
    parameter int IDX_W   = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGIT_W-1:0]         in_digit,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DEPTH*DIGIT_W-1:0]   out_path,
    output logic [3:0]                 out_depth,
    output logic [IDX_W-1:0]           out_leaf,
    output logic                       out_err_range,
    output logic                       out_err_overflow
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_EMIT    = 2'd3;

    localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);
    localparam logic [IDX_W-1:0] FANOUT_C = IDX_W'(FANOUT);

    logic [1:0]               state;
    logic [1:0]               state_next;

    logic [DEPTH*DIGIT_W-1:0] acc_path;
    logic [IDX_W-1:0]         acc_leaf;
    logic [3:0]               acc_count;
    logic                     acc_err_range;
    logic                     acc_err_ovf;

    logic [DEPTH*DIGIT_W-1:0] base_path;
    logic [IDX_W-1:0]         base_leaf;
    logic [3:0]               base_count;
    logic                     base_err_range;
    logic                     base_err_ovf;

    logic [DEPTH*DIGIT_W-1:0] nxt_path;
    logic [IDX_W-1:0]         nxt_leaf;
    logic [3:0]               nxt_count;
    logic                     nxt_err_range;
    logic                     nxt_err_ovf;

    logic                     accept_digit;
    logic                     in_xfer;

    assign in_ready  = (state != S_EMIT);
    assign out_valid = (state == S_EMIT);
    assign in_xfer   = in_valid && in_ready;

    // A token arriving in IDLE starts from cleared accumulators, so the fold
    // below is the same for the first token and every later one.
    always_comb begin
        base_path      = acc_path;
        base_leaf      = acc_leaf;
        base_count     = acc_count;
        base_err_range = acc_err_range;
        base_err_ovf   = acc_err_ovf;
        if (state == S_IDLE) begin
            base_path      = '0;
            base_leaf      = '0;
            base_count     = '0;
            base_err_range = 1'b0;
            base_err_ovf   = 1'b0;
        end

        accept_digit  = (base_count < DEPTH_C);
        nxt_path      = base_path;
        nxt_leaf      = base_leaf;
        nxt_count     = base_count;
        nxt_err_range = base_err_range;
        nxt_err_ovf   = base_err_ovf;

        if (accept_digit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (base_count == 4'(i)) begin
                    nxt_path[i*DIGIT_W +: DIGIT_W] = in_digit;
                end
            end
            nxt_leaf      = base_leaf * FANOUT_C + IDX_W'(in_digit);
            nxt_count     = base_count + 4'd1;
            nxt_err_range = base_err_range || (32'(in_digit) >= FANOUT);
        end else begin
            nxt_err_ovf   = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_COLLECT, S_DRAIN: begin
                if (in_valid) begin
                    if (in_last) begin
                        state_next = S_EMIT;
                    end else if (!accept_digit) begin
                        state_next = S_DRAIN;
                    end else begin
                        state_next = S_COLLECT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output registers are loaded only when a path completes, so they hold the
    // last emitted path while the next one is being collected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            acc_path         <= '0;
            acc_leaf         <= '0;
            acc_count        <= '0;
            acc_err_range    <= 1'b0;
            acc_err_ovf      <= 1'b0;
            out_path         <= '0;
            out_depth        <= '0;
            out_leaf         <= '0;
            out_err_range    <= 1'b0;
            out_err_overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (in_xfer) begin
                acc_path      <= nxt_path;
                acc_leaf      <= nxt_leaf;
                acc_count     <= nxt_count;
                acc_err_range <= nxt_err_range;
                acc_err_ovf   <= nxt_err_ovf;
                if (in_last) begin
                    out_path         <= nxt_path;
                    out_depth        <= nxt_count;
                    out_leaf         <= nxt_leaf;
                    out_err_range    <= nxt_err_range;
                    out_err_overflow <= nxt_err_ovf;
                end
            end
        end
    end

endmodule
